tile_scheduler: RTL and testbench

//   Walks the tile loop nest of one decoded layer: row groups (outer), K tiles, then D tiles (inner).

---
 rtl/tile_scheduler_pkg.sv | 27 ++
 rtl/tile_scheduler_if.sv | 31 +++
 rtl/tile_scheduler_loop_ctr.sv | 35 +++
 rtl/tile_scheduler.sv | 135 +++++++++++++
 tb/tb_tile_scheduler.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/tile_scheduler_pkg.sv
// Shared types for the tile scheduler: FSM states, layer-type codes and the
// tile command record.
package tile_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] LT_PW  = 2'd0;
  localparam logic [1:0] LT_DW  = 2'd1;
  localparam logic [1:0] LT_STD = 2'd2;
  localparam logic [1:0] LT_LIN = 2'd3;

  typedef struct packed {
    logic [6:0]  row;
    logic [6:0]  rows;
    logic [10:0] d;
    logic [6:0]  d_len;
    logic [10:0] k;
    logic [6:0]  k_len;
    logic        first;
    logic        last;
  } cmd_t;

endpackage

// File: rtl/tile_scheduler_if.sv
// Tile command channel from the scheduler to the load/compute/store engines,
// plus the engines' per-tile completion pulse.
interface tile_scheduler_if;

  // A command transfers on a rising clk edge where cmd_valid_o && cmd_ready_i;
  // once cmd_valid_o is raised, every cmd field holds until that transfer.
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic [6:0]  cmd_row_o;
  logic [6:0]  cmd_rows_o;
  logic [10:0] cmd_d_o;
  logic [6:0]  cmd_d_len_o;
  logic [10:0] cmd_k_o;
  logic [6:0]  cmd_k_len_o;
  logic        cmd_first_o;
  logic        cmd_last_o;
  logic        tile_done_i;

  modport master (
    output cmd_valid_o, cmd_row_o, cmd_rows_o, cmd_d_o, cmd_d_len_o,
           cmd_k_o, cmd_k_len_o, cmd_first_o, cmd_last_o,
    input  cmd_ready_i, tile_done_i
  );

  modport slave (
    input  cmd_valid_o, cmd_row_o, cmd_rows_o, cmd_d_o, cmd_d_len_o,
           cmd_k_o, cmd_k_len_o, cmd_first_o, cmd_last_o,
    output cmd_ready_i, tile_done_i
  );

endinterface

// File: rtl/tile_scheduler_loop_ctr.sv
// One loop dimension of the tile nest: base advances by tile, len is the
// clipped tile size, last flags the final tile; wraps to 0 when stepped at last.
module tile_loop_ctr #(
    parameter int W  = 11,
    parameter int LW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step,
    input  logic [W-1:0]  bound,
    input  logic [LW-1:0] tile,
    output logic [W-1:0]  base,
    output logic [LW-1:0] len,
    output logic          last
);

  logic [W:0]   next_sum;
  logic [W-1:0] rem;

  assign next_sum = {1'b0, base} + (W+1)'(tile);
  assign rem      = bound - base;
  assign last     = (next_sum >= {1'b0, bound});
  // rem only wins when it is <= tile, so it always fits in LW bits
  assign len      = (W'(tile) < rem) ? tile : rem[LW-1:0];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      base <= '0;
    end else if (step) begin
      base <= last ? '0 : next_sum[W-1:0];
    end
  end

endmodule

// File: rtl/tile_scheduler.sv
// Walks row groups (outer), K tiles, then D tiles (inner) for one layer and
// issues one command per tile, bounding the number of tiles in flight.
module tile_scheduler
  import tile_sched_pkg::*;
#(
    parameter int MAX_OUT = 4,
    parameter int OUT_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [1:0]       layer_type_i,
    input  logic [10:0]      in_D_i,
    input  logic [10:0]      out_K_i,
    input  logic [6:0]       out_R_i,
    input  logic [6:0]       tile_D_i,
    input  logic [6:0]       tile_K_i,
    input  logic [31:0]      tile_n_i,
    tile_scheduler_if.master cmd_if,
    output logic             busy_o,
    output logic             done_o,
    output state_t           dbg_state
);

  localparam logic [OUT_W-1:0] ONE     = OUT_W'(1);
  localparam logic [OUT_W-1:0] MAX_CNT = OUT_W'(MAX_OUT);

  state_t           state;
  logic [1:0]       lt_q;
  logic [10:0]      in_d_q, out_k_q;
  logic [6:0]       out_r_q, tile_d_q, tile_k_q, tile_n_q;
  logic [OUT_W-1:0] out_cnt, out_next;
  logic             valid_q, done_q;
  logic             is_dw, hs, final_tile, clear;
  logic [6:0]       tn_clamp;
  logic [10:0]      d_base, k_base;
  logic [6:0]       r_base, d_len, k_len, r_len;
  logic             d_last, k_last, r_last;

  assign is_dw      = (lt_q == LT_DW);
  assign hs         = valid_q && cmd_if.cmd_ready_i;
  assign final_tile = d_last && (k_last || is_dw) && r_last;
  assign clear      = (state == IDLE);
  assign tn_clamp   = (tile_n_i > {25'd0, out_R_i}) ? out_R_i : tile_n_i[6:0];

  always_comb begin
    out_next = out_cnt;
    if (hs) out_next = out_next + ONE;
    if (cmd_if.tile_done_i && (out_cnt != '0)) out_next = out_next - ONE;
  end

  tile_loop_ctr #(.W(11), .LW(7)) u_d_ctr (
    .clk(clk), .rst(rst), .clear(clear), .step(hs),
    .bound(in_d_q), .tile(tile_d_q), .base(d_base), .len(d_len), .last(d_last)
  );

  // DW collapses the K loop: its counter never steps
  tile_loop_ctr #(.W(11), .LW(7)) u_k_ctr (
    .clk(clk), .rst(rst), .clear(clear), .step(hs && d_last && !is_dw),
    .bound(out_k_q), .tile(tile_k_q), .base(k_base), .len(k_len), .last(k_last)
  );

  tile_loop_ctr #(.W(7), .LW(7)) u_r_ctr (
    .clk(clk), .rst(rst), .clear(clear), .step(hs && d_last && (k_last || is_dw)),
    .bound(out_r_q), .tile(tile_n_q), .base(r_base), .len(r_len), .last(r_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      out_cnt  <= '0;
      lt_q     <= '0;
      in_d_q   <= '0;
      out_k_q  <= '0;
      out_r_q  <= '0;
      tile_d_q <= '0;
      tile_k_q <= '0;
      tile_n_q <= '0;
    end else begin
      done_q  <= 1'b0;
      out_cnt <= out_next;
      if (abort_i) begin
        state   <= IDLE;
        valid_q <= 1'b0;
        out_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (start_i) begin
            lt_q     <= layer_type_i;
            in_d_q   <= in_D_i;
            out_k_q  <= out_K_i;
            out_r_q  <= out_R_i;
            tile_d_q <= (tile_D_i == 7'd0) ? 7'd1 : tile_D_i;
            tile_k_q <= (tile_K_i == 7'd0) ? 7'd1 : tile_K_i;
            tile_n_q <= (tn_clamp == 7'd0) ? 7'd1 : tn_clamp;
            if (in_D_i == '0 || out_K_i == '0 || out_R_i == '0) state <= DRAIN;
            else state <= ISSUE;
          end
          ISSUE: begin
            if (hs && final_tile) begin
              state   <= DRAIN;
              valid_q <= 1'b0;
            end else begin
              valid_q <= (out_next < MAX_CNT);
            end
          end
          DRAIN: if (out_cnt == '0) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Fields are forced to 0 whenever no command is offered
  assign cmd_if.cmd_valid_o = valid_q;
  assign cmd_if.cmd_row_o   = valid_q ? r_base : '0;
  assign cmd_if.cmd_rows_o  = valid_q ? r_len : '0;
  assign cmd_if.cmd_d_o     = valid_q ? d_base : '0;
  assign cmd_if.cmd_d_len_o = valid_q ? d_len : '0;
  assign cmd_if.cmd_k_o     = valid_q ? (is_dw ? d_base : k_base) : '0;
  assign cmd_if.cmd_k_len_o = valid_q ? (is_dw ? d_len : k_len) : '0;
  assign cmd_if.cmd_first_o = valid_q && (is_dw || d_base == '0);
  assign cmd_if.cmd_last_o  = valid_q && (is_dw || d_last);

  assign busy_o    = (state != IDLE);
  assign done_o    = done_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_tile_scheduler.sv
// Bench for tile_scheduler: randomized handshake/completion traffic against a
// loop-nest reference model and an outstanding-tile count model.
module tb_tile_scheduler;
  import tile_sched_pkg::*;

  localparam int MAX_OUT = 2;
  localparam int OUT_W   = 2;
  localparam int CW      = $bits(cmd_t);
  localparam int BUDGET  = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0, abort_i = 1'b0;
  logic [1:0]  layer_type_i = '0;
  logic [10:0] in_D_i = '0, out_K_i = '0;
  logic [6:0]  out_R_i = '0, tile_D_i = '0, tile_K_i = '0;
  logic [31:0] tile_n_i = '0;
  logic        busy_o, done_o;
  state_t      dbg_state;

  tile_scheduler_if bus();

  tile_scheduler #(.MAX_OUT(MAX_OUT), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .layer_type_i(layer_type_i), .in_D_i(in_D_i), .out_K_i(out_K_i),
    .out_R_i(out_R_i), .tile_D_i(tile_D_i), .tile_K_i(tile_K_i),
    .tile_n_i(tile_n_i), .cmd_if(bus), .busy_o(busy_o), .done_o(done_o),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [CW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint lmin(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction

  function automatic cmd_t observed();
    cmd_t c;
    c.row   = bus.cmd_row_o;
    c.rows  = bus.cmd_rows_o;
    c.d     = bus.cmd_d_o;
    c.d_len = bus.cmd_d_len_o;
    c.k     = bus.cmd_k_o;
    c.k_len = bus.cmd_k_len_o;
    c.first = bus.cmd_first_o;
    c.last  = bus.cmd_last_o;
    return c;
  endfunction

  // Reference: enumerate the loop nest directly from the layer parameters
  task automatic build(input logic [1:0] lt, input int d, k, r, td, tk, input logic [31:0] tn);
    longint tdg, tkg, tng, kend;
    cmd_t c;
    exp_q.delete();
    tdg = (td == 0) ? 1 : td;
    tkg = (tk == 0) ? 1 : tk;
    tng = (longint'(tn) > r) ? r : longint'(tn);
    if (tng == 0) tng = 1;
    if (d == 0 || k == 0 || r == 0) return;
    kend = (lt == LT_DW) ? 1 : k;
    for (longint rr = 0; rr < r; rr += tng)
      for (longint kk = 0; kk < kend; kk += tkg)
        for (longint dd = 0; dd < d; dd += tdg) begin
          c.row   = 7'(rr);
          c.rows  = 7'(lmin(tng, r - rr));
          c.d     = 11'(dd);
          c.d_len = 7'(lmin(tdg, d - dd));
          if (lt == LT_DW) begin
            c.k = c.d; c.k_len = c.d_len; c.first = 1'b1; c.last = 1'b1;
          end else begin
            c.k     = 11'(kk);
            c.k_len = 7'(lmin(tkg, k - kk));
            c.first = (dd == 0);
            c.last  = (dd + tdg >= d);
          end
          exp_q.push_back(c);
        end
  endtask

  // driver: one layer, cycle by cycle, with the scoreboard stepping alongside
  task automatic run_layer(input logic [1:0] lt, input int d, k, r, td, tk,
                           input logic [31:0] tn, input int rdy_pct, done_pct,
                           input int hold, abort_after, input bit busy_start);
    int  mout, pend, issued, cyc;
    bit  draining, exp_done, fin, hs, tdone, dec, exp_valid;
    mout = 0; pend = 0; issued = 0; cyc = 0;
    draining = 0; exp_done = 0; fin = 0;
    build(lt, d, k, r, td, tk, tn);
    @(negedge clk);
    layer_type_i = lt; in_D_i = 11'(d); out_K_i = 11'(k); out_R_i = 7'(r);
    tile_D_i = 7'(td); tile_K_i = 7'(tk); tile_n_i = tn; start_i = 1'b1;
    @(posedge clk);
    if (exp_q.size() == 0) draining = 1;
    @(negedge clk);
    start_i = 1'b0;
    check("start_valid", 64'(bus.cmd_valid_o), 64'(0));
    check("start_busy", 64'(busy_o), 64'(1));
    while (!fin) begin
      if (abort_after >= 0 && issued == abort_after) begin
        bus.cmd_ready_i = 1'b0; bus.tile_done_i = 1'b0; abort_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_valid", 64'(bus.cmd_valid_o), 64'(0));
        check("abort_busy", 64'(busy_o), 64'(0));
        check("abort_state", 64'(dbg_state), 64'(IDLE));
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("abort_no_done", 64'(done_o), 64'(0));
        end
        return;
      end
      bus.cmd_ready_i = ($urandom_range(99) < rdy_pct);
      if (pend > 0) tdone = (cyc >= hold) && ($urandom_range(99) < done_pct);
      else          tdone = ($urandom_range(99) < 5);
      bus.tile_done_i = tdone;
      start_i = busy_start && ($urandom_range(99) < 5);
      if (start_i) begin
        layer_type_i = 2'($urandom_range(3)); in_D_i = 11'($urandom_range(7));
        out_R_i = 7'($urandom_range(3)); tile_D_i = 7'($urandom_range(2));
      end
      hs = bus.cmd_valid_o && bus.cmd_ready_i;
      if (hs) begin
        void'(exp_q.pop_front());
        issued++;
      end
      @(posedge clk);
      exp_done = draining && (mout == 0);
      if (exp_done) draining = 0;
      dec  = tdone && (mout > 0);
      mout = mout + int'(hs) - int'(dec);
      if (tdone && pend > 0) pend--;
      if (hs) pend++;
      if (hs && exp_q.size() == 0) draining = 1;
      cyc++;
      @(negedge clk);
      check("done", 64'(done_o), 64'(exp_done));
      if (exp_done) begin
        fin = 1;
      end else begin
        exp_valid = (exp_q.size() > 0) && (mout < MAX_OUT);
        check("valid", 64'(bus.cmd_valid_o), 64'(exp_valid));
        check("busy", 64'(busy_o), 64'(1));
        if (bus.cmd_valid_o && exp_q.size() > 0) check("cmd", 64'(observed()), 64'(exp_q[0]));
      end
      if (!fin && cyc > BUDGET) begin
        check("timeout", 64'(1), 64'(0));
        fin = 1;
      end
    end
    bus.cmd_ready_i = 1'b0; bus.tile_done_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check("end_busy", 64'(busy_o), 64'(0));
    check("end_state", 64'(dbg_state), 64'(IDLE));
    check("end_done_pulse", 64'(done_o), 64'(0));
    check("end_left", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    bus.cmd_ready_i = 1'b0;
    bus.tile_done_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(bus.cmd_valid_o), 64'(0));
    check("rst_fields", 64'(observed()), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(IDLE));

    run_layer(LT_PW, 64, 64, 8, 32, 32, 32'd4, 100, 100, 0, -1, 0);
    run_layer(LT_PW, 40, 16, 7, 32, 16, 32'd4, 100, 60, 0, -1, 0);
    run_layer(LT_DW, 20, 5, 4, 10, 3, 32'd4, 100, 80, 0, -1, 0);
    run_layer(LT_PW, 40, 24, 7, 16, 8, 32'd3, 40, 70, 0, -1, 0);
    run_layer(LT_PW, 64, 64, 8, 32, 32, 32'd4, 100, 50, 30, -1, 0);
    run_layer(LT_PW, 64, 64, 8, 32, 32, 32'd4, 100, 100, 0, 3, 0);
    run_layer(LT_PW, 64, 64, 8, 32, 32, 32'd4, 80, 80, 0, -1, 1);
    run_layer(LT_PW, 0, 16, 4, 8, 8, 32'd2, 100, 100, 0, -1, 0);
    run_layer(LT_STD, 16, 0, 4, 8, 8, 32'd2, 100, 100, 0, -1, 0);
    run_layer(LT_DW, 16, 8, 0, 8, 8, 32'd2, 100, 100, 0, -1, 0);
    run_layer(LT_PW, 5, 3, 3, 0, 0, 32'd0, 90, 70, 0, -1, 0);
    run_layer(LT_LIN, 12, 9, 6, 5, 4, 32'hFFFF_FF00, 70, 70, 0, -1, 0);
    run_layer(LT_STD, 33, 17, 9, 8, 6, 32'd4, 60, 60, 0, -1, 0);

    for (int n = 0; n < 8; n++) begin
      run_layer(2'($urandom_range(3)), $urandom_range(1, 48), $urandom_range(1, 48),
                $urandom_range(1, 12), $urandom_range(8, 40), $urandom_range(8, 40),
                32'($urandom_range(0, 16)), $urandom_range(30, 100),
                $urandom_range(30, 100), 0, -1, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
